// File: rtl/spectrum_pixel_compress.sv
// Sums re^2 and im^2 words into bin power, compresses the power to an 8-bit piecewise-log
// pixel above a noise floor, and tracks the peak pixel of each frame.
module spectrum_pixel_compress #(
  parameter int BIN_BITS    = 6,
  parameter int NOISE_FLOOR = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  in_product,
  input  logic                in_last,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [7:0]          pix_data,
  output logic [BIN_BITS-1:0] pix_bin,
  output logic                pix_last,
  output logic [7:0]          frame_peak,
  output logic                frame_done
);

  typedef enum logic {PH_RE, PH_IM} phase_t;

  phase_t              phase, phase_nxt;
  logic                adv, xfer, pix_hs;
  logic [31:0]         word_clamp;
  logic [31:0]         re_p0;
  logic [31:0]         sum_p1;
  logic                last_p1;
  logic [BIN_BITS-1:0] bin_p1;
  logic                vld_p1;
  logic [BIN_BITS-1:0] bin_cnt;
  logic [7:0]          running_peak, peak_cand;

  // raw = 8*msb_index + three bits below the MSB; normalising the MSB to bit 31 pads short values
  function automatic logic [7:0] log_compress(input logic [31:0] s);
    logic [4:0]  m;
    logic [31:0] norm;
    m = 5'd0;
    for (int i = 0; i < 32; i++)
      if (s[i]) m = 5'(i);
    norm = s << (5'd31 - m);
    return (s == 32'd0) ? 8'd0 : {m, norm[30:28]};
  endfunction

  function automatic logic [7:0] floor_sub(input logic [7:0] raw);
    return (raw >= 8'(NOISE_FLOOR)) ? raw - 8'(NOISE_FLOOR) : 8'd0;
  endfunction

  assign adv        = !pix_valid || pix_ready;
  assign in_ready   = adv;
  assign xfer       = in_valid && adv;
  assign pix_hs     = pix_valid && pix_ready;
  assign word_clamp = in_product[31] ? 32'd0 : $unsigned(in_product);
  assign peak_cand  = (pix_data > running_peak) ? pix_data : running_peak;

  always_comb begin
    phase_nxt = phase;
    if (xfer)
      phase_nxt = (phase == PH_RE) ? PH_IM : PH_RE;
  end

  // Stage 0/1: capture re^2, then form the sum when im^2 arrives
  always_ff @(posedge clock) begin
    if (xfer && phase == PH_RE)
      re_p0 <= word_clamp;
    if (xfer && phase == PH_IM) begin
      sum_p1  <= re_p0 + word_clamp;
      last_p1 <= in_last;
      bin_p1  <= bin_cnt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase        <= PH_RE;
      bin_cnt      <= '0;
      vld_p1       <= 1'b0;
      pix_valid    <= 1'b0;
      pix_data     <= 8'd0;
      pix_bin      <= '0;
      pix_last     <= 1'b0;
      running_peak <= 8'd0;
      frame_peak   <= 8'd0;
      frame_done   <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (xfer && phase == PH_IM)
        bin_cnt <= in_last ? '0 : bin_cnt + 1'b1;
      // Stage 2: compress into the pixel register; both stages freeze while the pixel is held
      if (adv) begin
        vld_p1    <= xfer && (phase == PH_IM);
        pix_valid <= vld_p1;
        pix_data  <= floor_sub(log_compress(sum_p1));
        pix_bin   <= bin_p1;
        pix_last  <= last_p1;
      end
      frame_done <= pix_hs && pix_last;
      if (pix_hs) begin
        running_peak <= pix_last ? 8'd0 : peak_cand;
        if (pix_last)
          frame_peak <= peak_cand;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_pixel_compress.sv
// Scoreboard bench for spectrum_pixel_compress: pair stimulus pushes expected pixels,
// a monitor pops them on each pixel handshake and also tracks frame peak and done pulse.
module tb_spectrum_pixel_compress;

  localparam int BB = 6;

  logic          clock;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_product;
  logic          in_last;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic [BB-1:0] pix_bin;
  logic          pix_last;
  logic [7:0]    frame_peak;
  logic          frame_done;

  spectrum_pixel_compress #(.BIN_BITS(BB), .NOISE_FLOOR(16)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_bin(pix_bin),
    .pix_last(pix_last), .frame_peak(frame_peak), .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]    data;
    logic [BB-1:0] bin;
    logic          last;
  } sb_t;

  sb_t           sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [BB-1:0] m_bin = '0;
  logic [7:0]    m_run = 8'd0;
  logic [7:0]    exp_frame_peak = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pix(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic [31:0] f;
    int m;
    int raw;
    s = (a[31] ? 32'd0 : a) + (b[31] ? 32'd0 : b);
    if (s == 32'd0) return 8'd0;
    m = 0;
    while ((s >> (m + 1)) != 32'd0) m++;
    if (m >= 3) f = (s >> (m - 3)) & 32'd7;
    else        f = (s << (3 - m)) & 32'd7;
    raw = 8 * m + int'(f);
    return (raw >= 16) ? 8'(raw - 16) : 8'd0;
  endfunction

  task automatic send_word(input logic [31:0] w, input logic l, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_product = w; in_last = l;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    if (in_ready) begin
      @(posedge clock);
      ok = 1'b1;
    end else begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] re, input logic [31:0] im, input logic l, input int gap);
    bit ok;
    sb_t e;
    send_word(re, 1'b0, ok);
    repeat (gap) @(negedge clock);
    send_word(im, l, ok);
    if (ok) begin
      e.data = model_pix(re, im);
      e.bin  = m_bin;
      e.last = l;
      sb.push_back(e);
      m_bin = l ? '0 : m_bin + 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_bin", 32'(pix_bin), 32'd0);
    check("rst_pix_last", 32'(pix_last), 32'd0);
    check("rst_frame_peak", 32'(frame_peak), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  // Monitor: compares each handshaken pixel and the frame summary one cycle later
  initial begin
    sb_t  e;
    logic exp_done;
    logic cur_done;
    exp_done = 1'b0;
    forever begin
      @(negedge clock); #2;
      if (!resetn) begin
        exp_done = 1'b0;
        continue;
      end
      cur_done = exp_done;
      exp_done = 1'b0;
      check("frame_done", 32'(frame_done), 32'(cur_done));
      if (cur_done) check("frame_peak", 32'(frame_peak), 32'(exp_frame_peak));
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("pix_bin", 32'(pix_bin), 32'(e.bin));
          check("pix_last", 32'(pix_last), 32'(e.last));
          if (e.data > m_run) m_run = e.data;
          if (e.last) begin
            exp_frame_peak = m_run;
            m_run = 8'd0;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    resetn = 1'b0; in_valid = 1'b0; in_product = 32'd0; in_last = 1'b0; pix_ready = 1'b1;
    repeat (2) @(negedge clock);
    #2 check_reset_outputs();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Basic frame: 112, 156, 2, 232; the second pair has an idle gap between words
    send_pair(32'h0001_0000, 32'd0, 1'b0, 0);
    send_pair(32'h0030_0000, 32'd0, 1'b0, 3);
    send_pair(32'd5, 32'd0, 1'b0, 0);
    send_pair(32'h4000_0000, 32'h4000_0000, 1'b1, 0);
    wait_drain();

    // Zero power, tiny power, and a corrupt negative re^2
    send_pair(32'd0, 32'd0, 1'b0, 0);
    send_pair(32'd7, 32'd0, 1'b0, 0);
    send_pair(32'hFFFF_FFFF, 32'h0001_0000, 1'b1, 0);
    wait_drain();

    // Backpressure with a continuous input stream
    fork
      begin
        send_pair(32'h0100_0000, 32'd0, 1'b0, 0);
        send_pair(32'h0000_0100, 32'd9, 1'b0, 0);
        send_pair(32'h2000_0000, 32'h0000_1000, 1'b0, 0);
        send_pair(32'd3, 32'd1, 1'b1, 0);
      end
      begin
        pix_ready = 1'b0;
        repeat (4) @(negedge clock);
        #2 check("stall_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        pix_ready = 1'b1;
      end
    join
    wait_drain();

    // Two frames: peaks 200 then 50
    send_pair(32'h0800_0000, 32'd0, 1'b0, 0);
    send_pair(32'h0001_0000, 32'd0, 1'b1, 0);
    send_pair(32'h0000_0140, 32'd0, 1'b0, 0);
    send_pair(32'd3, 32'd0, 1'b1, 0);
    wait_drain();

    // Random words under random backpressure
    fork
      begin
        for (int i = 0; i < 16; i++)
          send_pair($urandom & 32'h3FFF_FFFF >> $urandom_range(0, 29),
                    $urandom & 32'h3FFF_FFFF >> $urandom_range(0, 29),
                    (i == 7 || i == 15), 0);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          pix_ready = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        pix_ready = 1'b1;
      end
    join
    pix_ready = 1'b1;
    wait_drain();

    // Reset mid-frame after a lone re^2 word
    send_pair(32'h4000_0000, 32'd0, 1'b0, 0);
    send_word(32'h7FFF_FFFF, 1'b0, ok);
    wait_drain();
    resetn = 1'b0;
    m_bin = '0; m_run = 8'd0; exp_frame_peak = 8'd0;
    sb.delete();
    @(negedge clock);
    #2 check_reset_outputs();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    send_pair(32'h0001_0000, 32'd0, 1'b1, 0);
    wait_drain();
    check("post_reset_frame_peak", 32'(frame_peak), 32'd112);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
